// File: rtl/ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_prefetch
// Purpose  : Instruction fetch unit. Generates the PC, issues in-order fetch
//            requests on the RIB master side and buffers up to two fetched
//            instructions in a 2-entry FIFO in front of decode. A jump
//            flushes the FIFO, discards in-flight responses and restarts
//            fetch at the target address.
// Ports    :
//   clk           in   core clock
//   rst           in   asynchronous, active-low reset
//   jump_flag_i   in   redirect request (same cycle as jump_addr_i)
//   jump_addr_i   in   redirect target, word aligned
//   hold_flag_i   in   [0]=hold PC, [1]=hold decode, [2] unused
//   req_o         out  fetch request valid
//   req_addr_o    out  fetch address (current PC)
//   req_ready_i   in   bus accepts request when req_o && req_ready_i
//   rsp_valid_i   in   read data valid, in request order
//   rsp_data_i    in   instruction word
//   inst_valid_o  out  instruction presented to decode (consumed same cycle)
//   inst_o        out  instruction word, NOP_INST when not valid
//   inst_addr_o   out  instruction address, 0 when not valid
// Revision : 1.0 - initial release
// ============================================================================
module ifu_prefetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST   = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic [2:0]  hold_flag_i,
  output logic        req_o,
  output logic [31:0] req_addr_o,
  input  logic        req_ready_i,
  input  logic        rsp_valid_i,
  input  logic [31:0] rsp_data_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o
);

  // PC and bookkeeping counters (each 0..2)
  logic [31:0] pc_q, pc_d;
  logic [1:0]  outst_q, outst_d;
  logic [1:0]  drop_q, drop_d;
  logic [1:0]  cnt_q, cnt_d;

  // Pending address queue: addresses of accepted requests, oldest first
  logic [31:0] aq_addr_q [2];
  logic        aq_rd_q, aq_rd_d;
  logic        aq_wr_q, aq_wr_d;

  // Output FIFO of {addr, data}
  logic [31:0] fifo_addr_q [2];
  logic [31:0] fifo_data_q [2];
  logic        fifo_rd_q, fifo_rd_d;
  logic        fifo_wr_q, fifo_wr_d;

  logic        accept;
  logic        rsp_take;
  logic        rsp_drop;
  logic        fifo_push;
  logic        fifo_pop;
  logic        credit_ok;
  logic [2:0]  credit_sum;
  logic        unused_hold_bit;

  assign unused_hold_bit = hold_flag_i[2];

  // Every accepted request reserves a FIFO slot until it is consumed, so the
  // FIFO can never overflow regardless of response latency.
  assign credit_sum = {1'b0, outst_q} + {1'b0, cnt_q};
  assign credit_ok  = credit_sum < 3'd2;

  // Gated with rst so no request is shown while reset is asserted.
  assign req_o      = rst && !jump_flag_i && !hold_flag_i[0] && credit_ok;
  assign req_addr_o = pc_q;
  assign accept     = req_o && req_ready_i;

  // Responses with nothing outstanding are out of contract; ignore them.
  assign rsp_take   = rsp_valid_i && (outst_q != 2'd0);
  assign rsp_drop   = drop_q != 2'd0;
  // A response arriving in the jump cycle belongs to the old stream.
  assign fifo_push  = rsp_take && !rsp_drop && !jump_flag_i;

  assign inst_valid_o = (cnt_q != 2'd0) && !hold_flag_i[1] && !jump_flag_i;
  assign fifo_pop     = inst_valid_o;
  assign inst_o       = inst_valid_o ? fifo_data_q[fifo_rd_q] : NOP_INST;
  assign inst_addr_o  = inst_valid_o ? fifo_addr_q[fifo_rd_q] : 32'h0;

  always_comb begin
    pc_d      = pc_q;
    outst_d   = outst_q;
    drop_d    = drop_q;
    cnt_d     = cnt_q;
    aq_rd_d   = aq_rd_q;
    aq_wr_d   = aq_wr_q;
    fifo_rd_d = fifo_rd_q;
    fifo_wr_d = fifo_wr_q;

    // In-flight tracking is never flushed: late responses still arrive and
    // must pop their queue entry even when they are dropped.
    outst_d = outst_q + {1'b0, accept} - {1'b0, rsp_take};
    aq_wr_d = aq_wr_q ^ accept;
    aq_rd_d = aq_rd_q ^ rsp_take;

    if (accept) begin
      pc_d = pc_q + 32'd4;
    end

    if (rsp_take && rsp_drop) begin
      drop_d = drop_q - 2'd1;
    end

    if (jump_flag_i) begin
      pc_d      = jump_addr_i;
      // No request is accepted in a jump cycle, so everything still
      // outstanding after this cycle's response must be discarded.
      drop_d    = outst_q - {1'b0, rsp_take};
      cnt_d     = 2'd0;
      fifo_rd_d = 1'b0;
      fifo_wr_d = 1'b0;
    end else begin
      cnt_d     = cnt_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
      fifo_rd_d = fifo_rd_q ^ fifo_pop;
      fifo_wr_d = fifo_wr_q ^ fifo_push;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= RESET_ADDR;
      outst_q   <= 2'd0;
      drop_q    <= 2'd0;
      cnt_q     <= 2'd0;
      aq_rd_q   <= 1'b0;
      aq_wr_q   <= 1'b0;
      fifo_rd_q <= 1'b0;
      fifo_wr_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
      cnt_q     <= cnt_d;
      aq_rd_q   <= aq_rd_d;
      aq_wr_q   <= aq_wr_d;
      fifo_rd_q <= fifo_rd_d;
      fifo_wr_q <= fifo_wr_d;
    end
  end

  // Storage arrays carry no reset; validity is tracked by the counters.
  always_ff @(posedge clk) begin
    if (accept) begin
      aq_addr_q[aq_wr_q] <= pc_q;
    end
    if (fifo_push) begin
      fifo_addr_q[fifo_wr_q] <= aq_addr_q[aq_rd_q];
      fifo_data_q[fifo_wr_q] <= rsp_data_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_prefetch
// Purpose  : Self-checking bench for ifu_prefetch. A bus model returns
//            in-order responses with programmable latency; accepted request
//            addresses are pushed to a scoreboard and popped when decode
//            consumes an instruction.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_prefetch;

  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] NOP_INST   = 32'h0000_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic [2:0]  hold_flag_i;
  logic        req_o;
  logic [31:0] req_addr_o;
  logic        req_ready_i;
  logic        rsp_valid_i;
  logic [31:0] rsp_data_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;

  ifu_prefetch #(
    .RESET_ADDR(RESET_ADDR),
    .NOP_INST  (NOP_INST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .jump_flag_i (jump_flag_i),
    .jump_addr_i (jump_addr_i),
    .hold_flag_i (hold_flag_i),
    .req_o       (req_o),
    .req_addr_o  (req_addr_o),
    .req_ready_i (req_ready_i),
    .rsp_valid_i (rsp_valid_i),
    .rsp_data_i  (rsp_data_i),
    .inst_valid_o(inst_valid_o),
    .inst_o      (inst_o),
    .inst_addr_o (inst_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } bus_t;

  bus_t        busq[$];
  logic [31:0] sbq[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat_min  = 1;
  int lat_max  = 1;
  int rdy_pct  = 100;
  int n_inst   = 0;
  int first_valid = -1;
  int rel_cyc  = 0;
  logic last_jump;

  // Bench-side model state
  logic [31:0] m_pc;
  int          m_outst;
  int          m_cnt;
  int          m_drop;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pc    = RESET_ADDR;
    m_outst = 0;
    m_cnt   = 0;
    m_drop  = 0;
    busq.delete();
    sbq.delete();
  endtask

  // One clock cycle. jmode: 0 none, 1 jump, 2 jump only if a response lands
  // this cycle while exactly one request is outstanding.
  task automatic step(input logic rst_v, input int jmode, input logic [31:0] jaddr,
                      input logic [2:0] hold);
    bus_t        head;
    logic        rv;
    logic        jmp;
    logic        exp_req;
    logic        exp_val;
    logic        push;
    logic [31:0] raddr;
    logic [31:0] ea;
    @(negedge clk);
    cyc++;
    if (rst_v && !rst) rel_cyc = cyc;
    rst = rst_v;
    if (!rst_v) model_reset();
    rv    = 1'b0;
    raddr = 32'h0;
    if (rst_v && busq.size() > 0 && busq[0].due <= cyc) begin
      head  = busq.pop_front();
      rv    = 1'b1;
      raddr = head.addr;
    end
    jmp = rst_v && ((jmode == 1) || (jmode == 2 && rv && m_outst == 1));
    last_jump   = jmp;
    jump_flag_i = jmp;
    jump_addr_i = jaddr;
    hold_flag_i = hold;
    req_ready_i = ($urandom_range(99, 0) < rdy_pct);
    rsp_valid_i = rv;
    rsp_data_i  = rv ? mem_word(raddr) : $urandom;
    #1;
    exp_req = rst_v && !jmp && !hold[0] && ((m_outst + m_cnt) < 2);
    check("req_o", req_o, exp_req);
    if (exp_req && req_ready_i) begin
      check("req_addr", req_addr_o, m_pc);
      head.addr = m_pc;
      head.due  = cyc + $urandom_range(lat_max, lat_min);
      busq.push_back(head);
      sbq.push_back(m_pc);
      m_pc    = m_pc + 32'd4;
      m_outst = m_outst + 1;
    end
    exp_val = rst_v && (m_cnt != 0) && !hold[1] && !jmp;
    check("inst_valid", inst_valid_o, exp_val);
    if (exp_val) begin
      if (sbq.size() == 0) begin
        check("scoreboard_nonempty", 32'(sbq.size()), 32'd1);
      end else begin
        ea = sbq.pop_front();
        check("inst_addr", inst_addr_o, ea);
        check("inst_data", inst_o, mem_word(ea));
        n_inst++;
        if (first_valid < 0) first_valid = cyc - rel_cyc;
      end
    end else begin
      check("nop_inst", inst_o, NOP_INST);
      check("nop_addr", inst_addr_o, 32'h0);
    end
    push = 1'b0;
    if (rv) begin
      m_outst = m_outst - 1;
      if (m_drop > 0) begin
        m_drop = m_drop - 1;
      end else if (!jmp) begin
        push = 1'b1;
        if (m_cnt >= 2) check("fifo_room", 32'(m_cnt), 32'd1);
      end
    end
    if (jmp) begin
      m_cnt  = 0;
      m_drop = m_outst;
      m_pc   = jaddr;
      sbq.delete();
    end else begin
      m_cnt = m_cnt + (push ? 1 : 0) - (exp_val ? 1 : 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int i;
    rst         = 1'b0;
    jump_flag_i = 1'b0;
    jump_addr_i = 32'h0;
    hold_flag_i = 3'b000;
    req_ready_i = 1'b0;
    rsp_valid_i = 1'b0;
    rsp_data_i  = 32'h0;
    last_jump   = 1'b0;
    model_reset();

    // Reset state, then straight-line fetch with k=1 and always-ready bus
    repeat (3) step(1'b0, 0, 32'h0, 3'b000);
    lat_min = 1; lat_max = 1; rdy_pct = 100;
    repeat (12) step(1'b1, 0, 32'h0, 3'b000);
    check("first_valid_cycle", first_valid, 32'd2);

    // Hold 011 with two outstanding and an empty FIFO
    lat_min = 3; lat_max = 3;
    step(1'b1, 1, 32'h40, 3'b000);
    for (i = 0; i < 40; i++) begin
      if (m_outst == 2 && m_cnt == 0) break;
      step(1'b1, 0, 32'h0, 3'b000);
    end
    check("hold_setup", 32'(m_outst == 2 && m_cnt == 0), 32'd1);
    repeat (5) step(1'b1, 0, 32'h0, 3'b011);
    check("hold_fifo_full", 32'(m_cnt), 32'd2);
    repeat (10) step(1'b1, 0, 32'h0, 3'b000);

    // Jump with a buffered instruction and an outstanding request
    step(1'b1, 1, 32'h80, 3'b000);
    repeat (2) step(1'b1, 0, 32'h0, 3'b000);
    for (i = 0; i < 40; i++) begin
      if (m_outst >= 1 && m_cnt >= 1) break;
      step(1'b1, 0, 32'h0, 3'b011);
    end
    check("jump_setup", 32'(m_outst >= 1 && m_cnt >= 1), 32'd1);
    step(1'b1, 1, 32'h100, 3'b011);
    repeat (12) step(1'b1, 0, 32'h0, 3'b000);

    // Jump in the same cycle a response lands with one outstanding
    lat_min = 2; lat_max = 2;
    for (i = 0; i < 40; i++) begin
      step(1'b1, 2, 32'h200, 3'b000);
      if (last_jump) break;
    end
    check("jump_on_rsp", 32'(last_jump), 32'd1);
    step(1'b1, 0, 32'h0, 3'b000);
    check("jump_on_rsp_drop", 32'(m_drop), 32'd0);
    repeat (8) step(1'b1, 0, 32'h0, 3'b000);

    // PC wrap at the top of the address space
    lat_min = 1; lat_max = 2;
    step(1'b1, 1, 32'hFFFF_FFF8, 3'b000);
    repeat (12) step(1'b1, 0, 32'h0, 3'b000);

    // Random ready, latency 1..4, occasional holds and jumps
    lat_min = 1; lat_max = 4; rdy_pct = 50;
    base = n_inst;
    for (i = 0; i < 3000 && (n_inst - base) < 100; i++) begin
      int r;
      r = $urandom_range(99, 0);
      if (r < 3)
        step(1'b1, 1, $urandom & 32'h0000_FFFC, 3'b000);
      else if (r < 8)
        step(1'b1, 0, 32'h0, 3'b001);
      else if (r < 13)
        step(1'b1, 0, 32'h0, 3'b011);
      else
        step(1'b1, 0, 32'h0, 3'b000);
    end
    check("random_inst_count", 32'((n_inst - base) >= 100), 32'd1);

    // Reset asserted asynchronously while the FIFO is full
    lat_min = 1; lat_max = 1; rdy_pct = 100;
    for (i = 0; i < 40; i++) begin
      if (m_outst + m_cnt == 2) break;
      step(1'b1, 0, 32'h0, 3'b000);
    end
    for (i = 0; i < 40; i++) begin
      if (m_cnt == 2) break;
      step(1'b1, 0, 32'h0, 3'b011);
    end
    check("reset_setup_full", 32'(m_cnt), 32'd2);
    @(negedge clk);
    cyc++;
    jump_flag_i = 1'b0;
    hold_flag_i = 3'b000;
    req_ready_i = 1'b0;
    rsp_valid_i = 1'b0;
    #1;
    check("prereset_valid", inst_valid_o, 1'b1);
    if (sbq.size() > 0) check("prereset_addr", inst_addr_o, sbq[0]);
    #1;
    rst = 1'b0;
    #1;
    check("reset_valid", inst_valid_o, 1'b0);
    check("reset_inst", inst_o, NOP_INST);
    check("reset_addr", inst_addr_o, 32'h0);
    check("reset_req", req_o, 1'b0);
    model_reset();
    repeat (2) step(1'b0, 0, 32'h0, 3'b000);
    first_valid = -1;
    repeat (10) step(1'b1, 0, 32'h0, 3'b000);
    check("restart_first_valid", first_valid, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
